// File: rtl/id_ex_skid_stage_if.sv
// ID/EX stage bus: decode-side handshake and fields in, execute-side handshake and
// registered fields out. master = surrounding pipeline, slave = the stage itself.
interface id_ex_skid_stage_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   inst_addr;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;
  logic [XLEN-1:0]   imm_data;
  logic [31:0]       instruction;
  logic [WB_W-1:0]   wb;
  logic [M_W-1:0]    m;
  logic [2:0]        ex;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   inst_addr_out;
  logic [XLEN-1:0]   read_data1_out;
  logic [XLEN-1:0]   read_data2_out;
  logic [XLEN-1:0]   imm_data_out;
  logic [REG_AW-1:0] rs1_out;
  logic [REG_AW-1:0] rs2_out;
  logic [REG_AW-1:0] rd_out;
  logic [3:0]        funct;
  logic [WB_W-1:0]   wb_out;
  logic [M_W-1:0]    m_out;
  logic [1:0]        alu_op;
  logic              alu_src;

  modport master (
    output in_valid, inst_addr, rs1, rs2, rd, read_data1, read_data2, imm_data,
           instruction, wb, m, ex, out_ready,
    input  in_ready, out_valid, inst_addr_out, read_data1_out, read_data2_out,
           imm_data_out, rs1_out, rs2_out, rd_out, funct, wb_out, m_out, alu_op, alu_src
  );

  modport slave (
    input  in_valid, inst_addr, rs1, rs2, rd, read_data1, read_data2, imm_data,
           instruction, wb, m, ex, out_ready,
    output in_ready, out_valid, inst_addr_out, read_data1_out, read_data2_out,
           imm_data_out, rs1_out, rs2_out, rd_out, funct, wb_out, m_out, alu_op, alu_src
  );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with valid/ready flow control, a one-entry skid buffer,
// synchronous flush with bubble insertion and saturating stall/flush counters.
module id_ex_skid_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  id_ex_skid_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic [XLEN-1:0]   inst_addr;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   imm_data;
    logic [31:0]       instruction;
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [2:0]        ex;
  } skid_t;

  // OUT keeps only the decoded funct bits rather than the raw instruction word.
  typedef struct packed {
    logic [XLEN-1:0]   inst_addr;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   imm_data;
    logic [3:0]        funct;
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [2:0]        ex;
  } out_t;

  function automatic out_t to_out(input skid_t s);
    out_t o;
    o.inst_addr  = s.inst_addr;
    o.rs1        = s.rs1;
    o.rs2        = s.rs2;
    o.rd         = s.rd;
    o.read_data1 = s.read_data1;
    o.read_data2 = s.read_data2;
    o.imm_data   = s.imm_data;
    o.funct      = {s.instruction[30], s.instruction[14:12]};
    o.wb         = s.wb;
    o.m          = s.m;
    o.ex         = s.ex;
    return o;
  endfunction

  out_t             out_q, out_d;
  skid_t            skid_q, skid_d, in_ent;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             accept, drain;

  always_comb begin
    in_ent.inst_addr   = bus.inst_addr;
    in_ent.rs1         = bus.rs1;
    in_ent.rs2         = bus.rs2;
    in_ent.rd          = bus.rd;
    in_ent.read_data1  = bus.read_data1;
    in_ent.read_data2  = bus.read_data2;
    in_ent.imm_data    = bus.imm_data;
    in_ent.instruction = bus.instruction;
    in_ent.wb          = bus.wb;
    in_ent.m           = bus.m;
    in_ent.ex          = bus.ex;
  end

  // in_ready is the inverted skid flag, so it never depends combinationally on out_ready.
  assign accept = bus.in_valid && !skid_valid_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    stall_d      = stall_q;
    flush_cnt_d  = flush_cnt_q;

    if (out_valid_q && !bus.out_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_d.wb     = '0;
      out_d.m      = '0;
      out_d.ex     = '0;
      if ((out_valid_q || skid_valid_q) && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else if (skid_valid_q && drain) begin
      out_d        = to_out(skid_q);
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || drain)) begin
      out_d       = to_out(in_ent);
      out_valid_d = 1'b1;
    end else if (accept && out_valid_q && !bus.out_ready) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end else if (drain && !accept) begin
      // Bubble: kill control so execute sees a NOP; data fields keep their values.
      out_valid_d = 1'b0;
      out_d.wb    = '0;
      out_d.m     = '0;
      out_d.ex    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
      flush_cnt_q  <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.in_ready       = !skid_valid_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.inst_addr_out  = out_q.inst_addr;
  assign bus.read_data1_out = out_q.read_data1;
  assign bus.read_data2_out = out_q.read_data2;
  assign bus.imm_data_out   = out_q.imm_data;
  assign bus.rs1_out        = out_q.rs1;
  assign bus.rs2_out        = out_q.rs2;
  assign bus.rd_out         = out_q.rd;
  assign bus.funct          = out_q.funct;
  assign bus.wb_out         = out_q.wb;
  assign bus.m_out          = out_q.m;
  assign bus.alu_op         = out_q.ex[2:1];
  assign bus.alu_src        = out_q.ex[0];
  assign stall_cycles       = stall_q;
  assign flush_count        = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench: a queue-based FIFO model (depth 2) predicts every output each cycle;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_id_ex_skid_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  stall_cycles2, flush_count2;

  always #5 clk = ~clk;

  id_ex_skid_stage_if #(.XLEN(64), .REG_AW(5), .WB_W(2), .M_W(3)) u_if1 ();
  id_ex_skid_stage_if #(.XLEN(64), .REG_AW(5), .WB_W(2), .M_W(3)) u_if2 ();

  id_ex_skid_stage #(.XLEN(64), .REG_AW(5), .WB_W(2), .M_W(3), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (u_if1.slave),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  id_ex_skid_stage #(.XLEN(64), .REG_AW(5), .WB_W(2), .M_W(3), .CNT_W(2)) u_dut_sat (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (u_if2.slave),
    .stall_cycles (stall_cycles2),
    .flush_count  (flush_count2)
  );

  assign u_if2.in_valid    = u_if1.in_valid;
  assign u_if2.inst_addr   = u_if1.inst_addr;
  assign u_if2.rs1         = u_if1.rs1;
  assign u_if2.rs2         = u_if1.rs2;
  assign u_if2.rd          = u_if1.rd;
  assign u_if2.read_data1  = u_if1.read_data1;
  assign u_if2.read_data2  = u_if1.read_data2;
  assign u_if2.imm_data    = u_if1.imm_data;
  assign u_if2.instruction = u_if1.instruction;
  assign u_if2.wb          = u_if1.wb;
  assign u_if2.m           = u_if1.m;
  assign u_if2.ex          = u_if1.ex;
  assign u_if2.out_ready   = u_if1.out_ready;

  typedef struct {
    logic [63:0] inst_addr;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rd1, rd2, imm;
    logic [31:0] instr;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [2:0]  ex;
  } ent_t;

  ent_t   mq[$];
  ent_t   last;
  longint stall_m, flush_m;
  int     n_cmp  = 0;
  int     n_fail = 0;
  bit     chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.inst_addr = u_if1.inst_addr;
    e.rs1 = u_if1.rs1;  e.rs2 = u_if1.rs2;  e.rd = u_if1.rd;
    e.rd1 = u_if1.read_data1;  e.rd2 = u_if1.read_data2;  e.imm = u_if1.imm_data;
    e.instr = u_if1.instruction;
    e.wb = u_if1.wb;  e.m = u_if1.m;  e.ex = u_if1.ex;
    return e;
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model: the stage is a FIFO of at most two entries; the head is what execute sees.
  initial begin
    mq.delete();
    last = '{default: '0};
    stall_m = 0;
    flush_m = 0;
    forever begin
      int n;
      bit rdy;
      @(posedge clk);
      n   = mq.size();
      rdy = (n < 2);
      if (!reset) begin
        mq.delete();
        last = '{default: '0};
        stall_m = 0;
        flush_m = 0;
      end else begin
        if (n > 0 && !u_if1.out_ready) stall_m++;
        if (flush) begin
          if (n > 0) flush_m++;
          mq.delete();
        end else begin
          if (n > 0 && u_if1.out_ready) void'(mq.pop_front());
          if (u_if1.in_valid && rdy) mq.push_back(cur_in());
        end
        if (mq.size() > 0) last = mq[0];
      end
      chk_en = 1;
    end
  end

  // Compare process: every output, every cycle, against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      logic [31:0] ins;
      v   = (mq.size() > 0);
      ins = last.instr;
      check("out_valid", 64'(u_if1.out_valid), 64'(v));
      check("in_ready", 64'(u_if1.in_ready), 64'(mq.size() < 2));
      check("inst_addr_out", u_if1.inst_addr_out, last.inst_addr);
      check("read_data1_out", u_if1.read_data1_out, last.rd1);
      check("read_data2_out", u_if1.read_data2_out, last.rd2);
      check("imm_data_out", u_if1.imm_data_out, last.imm);
      check("rs1_out", 64'(u_if1.rs1_out), 64'(last.rs1));
      check("rs2_out", 64'(u_if1.rs2_out), 64'(last.rs2));
      check("rd_out", 64'(u_if1.rd_out), 64'(last.rd));
      check("funct", 64'(u_if1.funct), 64'({ins[30], ins[14:12]}));
      check("wb_out", 64'(u_if1.wb_out), v ? 64'(last.wb) : 64'd0);
      check("m_out", 64'(u_if1.m_out), v ? 64'(last.m) : 64'd0);
      check("alu_op", 64'(u_if1.alu_op), v ? 64'(last.ex[2:1]) : 64'd0);
      check("alu_src", 64'(u_if1.alu_src), v ? 64'(last.ex[0]) : 64'd0);
      check("stall_cycles", 64'(stall_cycles), 64'(sat(stall_m, 65535)));
      check("flush_count", 64'(flush_count), 64'(sat(flush_m, 65535)));
      check("sat_stall_cycles", 64'(stall_cycles2), 64'(sat(stall_m, 3)));
      check("sat_flush_count", 64'(flush_count2), 64'(sat(flush_m, 3)));
      check("sat_out_valid", 64'(u_if2.out_valid), 64'(v));
    end
  end

  task automatic drive_rand(input bit valid);
    u_if1.in_valid    = valid;
    u_if1.inst_addr   = {$urandom, $urandom};
    u_if1.rs1         = 5'($urandom);
    u_if1.rs2         = 5'($urandom);
    u_if1.rd          = 5'($urandom);
    u_if1.read_data1  = {$urandom, $urandom};
    u_if1.read_data2  = {$urandom, $urandom};
    u_if1.imm_data    = {$urandom, $urandom};
    u_if1.instruction = $urandom;
    u_if1.wb          = 2'($urandom);
    u_if1.m           = 3'($urandom);
    u_if1.ex          = 3'($urandom);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    u_if1.out_ready = 1'b0;
    drive_rand(1'b1);

    // Reset held two cycles with in_valid high.
    nxt(); nxt();
    check("rst_in_ready", 64'(u_if1.in_ready), 64'd1);
    check("rst_out_valid", 64'(u_if1.out_valid), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    check("rst_rd_out", 64'(u_if1.rd_out), 64'd0);
    reset = 1'b1;
    drive_rand(1'b1);
    nxt();
    check("first_accept", 64'(u_if1.out_valid), 64'd1);

    // Streaming, 1-cycle latency.
    u_if1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1);
      u_if1.instruction = 32'h40A3_02B3;
      u_if1.rd = 5'(5 + i);
      nxt();
      check("stream_valid", 64'(u_if1.out_valid), 64'd1);
      check("stream_funct", 64'(u_if1.funct), 64'b1000);
      check("stream_rd", 64'(u_if1.rd_out), 64'(5 + i));
    end
    u_if1.in_valid = 1'b0;
    nxt();
    check("stream_end", 64'(u_if1.out_valid), 64'd0);
    check("stream_stall", 64'(stall_cycles), 64'd0);

    // Stall with skid: A held in OUT, B in SKID.
    u_if1.out_ready = 1'b0;
    drive_rand(1'b1);
    u_if1.inst_addr = 64'hA;
    nxt();
    drive_rand(1'b1);
    u_if1.inst_addr = 64'hB;
    nxt();
    u_if1.in_valid = 1'b0;
    check("skid_in_ready", 64'(u_if1.in_ready), 64'd0);
    nxt(); nxt();
    check("skid_head_a", u_if1.inst_addr_out, 64'hA);
    u_if1.out_ready = 1'b1;
    nxt();
    check("skid_head_b", u_if1.inst_addr_out, 64'hB);
    nxt();
    check("skid_drained", 64'(u_if1.out_valid), 64'd0);
    check("skid_stall3", 64'(stall_cycles), 64'd3);

    // Flush with A in OUT, B in SKID, C presented.
    u_if1.out_ready = 1'b0;
    drive_rand(1'b1);
    u_if1.wb = 2'b11; u_if1.m = 3'b111; u_if1.ex = 3'b111;
    nxt();
    drive_rand(1'b1);
    nxt();
    drive_rand(1'b1);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    u_if1.in_valid = 1'b0;
    check("flush_valid", 64'(u_if1.out_valid), 64'd0);
    check("flush_in_ready", 64'(u_if1.in_ready), 64'd1);
    check("flush_ctrl", 64'({u_if1.wb_out, u_if1.m_out, u_if1.alu_op, u_if1.alu_src}), 64'd0);
    check("flush_count1", 64'(flush_count), 64'd1);
    nxt();
    u_if1.out_ready = 1'b1;
    nxt();

    // Bubble after a single instruction.
    drive_rand(1'b1);
    u_if1.wb = 2'b11;
    u_if1.ex = 3'b101;
    nxt();
    u_if1.in_valid = 1'b0;
    check("bubble_wb", 64'(u_if1.wb_out), 64'd3);
    check("bubble_alu_op", 64'(u_if1.alu_op), 64'd2);
    check("bubble_alu_src", 64'(u_if1.alu_src), 64'd1);
    nxt();
    check("bubble_valid", 64'(u_if1.out_valid), 64'd0);
    check("bubble_ctrl", 64'({u_if1.wb_out, u_if1.alu_op, u_if1.alu_src}), 64'd0);

    // Six more stall cycles; 2-bit counter must sit at 3.
    u_if1.out_ready = 1'b0;
    drive_rand(1'b1);
    nxt();
    u_if1.in_valid = 1'b0;
    repeat (6) nxt();
    check("sat_stall3", 64'(stall_cycles2), 64'd3);
    u_if1.out_ready = 1'b1;
    nxt();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive_rand($urandom_range(0, 9) < 6);
      u_if1.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) != 0);
      nxt();
    end

    reset = 1'b0;
    flush = 1'b0;
    nxt();
    check("final_rst_sat", 64'(stall_cycles2), 64'd0);
    check("final_rst_stall", 64'(stall_cycles), 64'd0);
    check("final_rst_flush", 64'(flush_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
